// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream and instruction-memory write bus of the loader
//
// Purpose: bundles the host byte stream (valid/ready) and the instruction-memory
// write port that the loader drives.
// Modports:
//   master - the loader: consumes the byte stream, drives byte_ready and the imem write port
//   slave  - the opposite side: byte source plus instruction-memory write sink
// Signals:
//   byte_in[7:0], byte_valid   source -> loader
//   byte_ready                 loader -> source
//   imem_addr[ADDR_WIDTH-1:0], imem_data[31:0], imem_we   loader -> memory
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;
  logic                  imem_we;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output imem_addr,
    output imem_data,
    output imem_we
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  imem_addr,
    input  imem_data,
    input  imem_we
  );
endinterface

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream program loader for the instruction memory
//
// Purpose: receives a header byte (word count N, 0 = DEPTH words) followed by
// 4*N bytes, assembles big-endian 32-bit words and writes them to instruction
// memory addresses 0..N-1. When N < DEPTH a zero halt word is written at
// address N. The control unit is held suspended and in reset until the load
// completes successfully.
// Optional feature macro: LOADER_CHECKSUM_EN - a trailing checksum byte (XOR of
// all data bytes) is required after the data; a mismatch rejects the load.
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a load (only honoured when not busy)
//   bus        master modport: byte_in/byte_valid/byte_ready, imem_addr/imem_data/imem_we
//   cpu_hold   out  control unit suspend
//   cpu_rst_n  out  control unit reset, active low
//   busy       out  load in progress
//   done       out  last load completed (sticky until start/rst)
//   error      out  last load rejected (sticky until start/rst)
// All outputs are registered.
module instruction_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  instruction_loader_if.master bus,
  output logic                 cpu_hold,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // One extra bit so that a full-depth word count is representable.
  localparam int WIDX = ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_BYTE   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_TERM   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [WIDX-1:0] FULL_COUNT = WIDX'(DEPTH);

  logic [2:0]            state_q, state_d;
  logic [WIDX-1:0]       widx_q, widx_d;
  logic [WIDX-1:0]       nwords_q, nwords_d;
  logic [1:0]            bcnt_q, bcnt_d;
  // Only the first three bytes of a word need storing; the fourth goes
  // straight into imem_data together with them.
  logic [23:0]           asm_q, asm_d;

  logic                  byte_ready_q, byte_ready_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  imem_we_q, imem_we_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic                  fire;
  logic [WIDX-1:0]       widx_inc;
  logic                  hdr_illegal;

  // Handshake uses the registered ready that the source actually sees.
  assign fire        = bus.byte_valid && byte_ready_q;
  assign widx_inc    = widx_q + 1'b1;
  assign hdr_illegal = (32'(bus.byte_in) > 32'(DEPTH));

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    nwords_d    = nwords_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_HEADER;
          widx_d      = '0;
          bcnt_d      = '0;
          imem_addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d       = '0;
`endif
        end
      end

      S_HEADER: begin
        if (fire) begin
          if (bus.byte_in == 8'd0) begin
            nwords_d = FULL_COUNT;
            state_d  = S_BYTE;
          end else if (hdr_illegal) begin
            state_d  = S_ERROR;
          end else begin
            nwords_d = WIDX'(bus.byte_in);
            state_d  = S_BYTE;
          end
        end
      end

      S_BYTE: begin
        if (fire) begin
          asm_d  = {asm_q[15:0], bus.byte_in};
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ bus.byte_in;
`endif
          if (bcnt_q == 2'd3) begin
            imem_data_d = {asm_q, bus.byte_in};
            imem_addr_d = widx_q[ADDR_WIDTH-1:0];
            state_d     = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        widx_d = widx_inc;
        if (widx_inc < nwords_q) begin
          state_d = S_BYTE;
        end else if (nwords_q < FULL_COUNT) begin
          // Halt word right after the program; N < DEPTH so the address fits.
          imem_addr_d = nwords_q[ADDR_WIDTH-1:0];
          imem_data_d = '0;
          state_d     = S_TERM;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end

      S_TERM: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = S_CHECK;
`else
        state_d = S_DONE;
`endif
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (fire) begin
          state_d = (bus.byte_in == xor_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of the next state so they appear registered
    // in the same cycle the state becomes current.
    byte_ready_d = (state_d == S_HEADER) || (state_d == S_BYTE) || (state_d == S_CHECK);
    imem_we_d    = (state_d == S_WRITE) || (state_d == S_TERM);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    cpu_hold_d   = (state_d != S_DONE);
    cpu_rst_n_d  = (state_d == S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      widx_q       <= '0;
      nwords_q     <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      imem_we_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      nwords_q     <= nwords_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      imem_we_q    <= imem_we_d;
      cpu_hold_q   <= cpu_hold_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_data  = imem_data_q;
  assign bus.imem_we    = imem_we_q;
  assign cpu_hold       = cpu_hold_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, cpu_rst_n, busy, done, error;

  instruction_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe observed mid-cycle is one memory write.
  logic [AW+31:0] wr_q[$];
  int             wr_cyc_q[$];
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_q.push_back({bus.imem_addr, bus.imem_data});
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after a random idle gap; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    int   gap;
    logic rdy;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) step();
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      rdy = bus.byte_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  // One complete load with the expectations derived from the header and data.
  task automatic do_load(input logic [7:0] hdr, input logic [7:0] data[$], input int gap_max,
                         input logic [7:0] cks_delta, input bit mid_start);
    bit         ok;
    bit         legal;
    int         n;
    int         nexp;
    int         c;
    logic       any_rdy;
    logic [7:0] x;
    logic [31:0] ew;
    wr_q.delete();
    wr_cyc_q.delete();
    legal = (hdr == 8'd0) || (int'(hdr) <= DEPTH);
    n     = (hdr == 8'd0) ? DEPTH : int'(hdr);
    x     = 8'd0;
    foreach (data[i]) x ^= data[i];

    start = 1'b1;
    step();
    start = 1'b0;
    check("ready_after_start", bus.byte_ready, 1);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("hold_loading", {cpu_hold, cpu_rst_n}, 2'b10);

    send_byte(hdr, gap_max, ok);
    if (!legal) begin
      bus.byte_valid = 1'b0;
      check("err_flag", error, 1);
      check("err_outs", {busy, bus.byte_ready, cpu_hold, cpu_rst_n, done}, 5'b00100);
      bus.byte_in    = 8'hAA;
      bus.byte_valid = 1'b1;
      any_rdy = 1'b0;
      repeat (6) begin
        step();
        any_rdy |= bus.byte_ready;
      end
      bus.byte_valid = 1'b0;
      check("err_discard", any_rdy, 0);
      check("err_no_write", wr_q.size(), 0);
      check("err_sticky", error, 1);
    end else begin
      for (int w = 0; w < n; w++) begin
        for (int j = 0; j < 4; j++) begin
          if (mid_start && w == 0 && j == 1) start = 1'b1;
          send_byte(data[4*w+j], gap_max, ok);
          start = 1'b0;
          if (j == 3 && (w == 0 || w == n - 1)) begin
            check("we_latency", bus.imem_we, 1);
            check("ready_in_write", bus.byte_ready, 0);
          end
        end
      end
      bus.byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ cks_delta, gap_max, ok);
      bus.byte_valid = 1'b0;
      check("cks_done", done, (cks_delta == 8'd0));
      check("cks_error", error, (cks_delta != 8'd0));
`else
      c = 0;
      while (!(done || error) && c < 20) begin
        step();
        c++;
      end
      check("done_latency", c, (n < DEPTH) ? 2 : 1);
      check("done_flag", done, 1);
      check("release", {cpu_hold, cpu_rst_n, busy, error}, 4'b0100);
`endif
      nexp = n + ((n < DEPTH) ? 1 : 0);
      check("write_count", wr_q.size(), nexp);
      for (int i = 0; i < wr_q.size() && i < nexp; i++) begin
        ew = (i < n) ? {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]} : 32'd0;
        check($sformatf("write[%0d]", i), wr_q[i], {AW'(i), ew});
      end
      if (gap_max == 0 && n > 1 && wr_cyc_q.size() >= n)
        check("throughput", wr_cyc_q[n-1] - wr_cyc_q[0], (n - 1) * 5);
    end
    repeat (2) step();
  endtask

  task automatic rand_data(input int nb, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < nb; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] dq[$];
    logic [7:0] hdr;
    bit         ok;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b1;

    // Reset state, with a byte offered that must not be taken.
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_data", bus.imem_data, 0);
    check("rst_ctrl", {cpu_hold, cpu_rst_n, busy, done, error}, 5'b10000);
    check("rst_no_write", wr_q.size(), 0);
    bus.byte_valid = 1'b0;

    // Two-word program plus halt word.
    dq = {8'hF8, 8'h40, 8'h00, 8'h20, 8'h8B, 8'h02, 8'h00, 8'h41};
    do_load(8'h02, dq, 0, 8'd0, 1'b0);

    // Full memory, no halt word.
    rand_data(4 * DEPTH, dq);
    do_load(8'h00, dq, 0, 8'd0, 1'b0);

    // Smallest illegal header, then a load that must clear error.
    dq = {};
    do_load(8'h81, dq, 0, 8'd0, 1'b0);

    // Largest legal explicit count, with gaps.
    rand_data(4 * DEPTH, dq);
    do_load(8'h80, dq, 1, 8'd0, 1'b0);

    // Single word with random gaps and a start pulse while busy.
    rand_data(4, dq);
    do_load(8'h01, dq, 3, 8'd0, 1'b1);

    // Abort a second load after two data bytes.
    wr_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h01, 2, ok);
    send_byte(8'h5A, 2, ok);
    send_byte(8'hC3, 2, ok);
    rst = 1'b1;
    #1;
    check("abort_async", {bus.byte_ready, bus.imem_we, busy, cpu_hold, cpu_rst_n, done, error},
          7'b0001000);
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();
    bus.byte_valid = 1'b0;
    check("abort_no_write", wr_q.size(), 0);
    check("abort_idle", {bus.byte_ready, busy}, 2'b00);

    // Random loads, occasionally with an illegal header.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 4) == 0) hdr = 8'($urandom_range(129, 255));
      else hdr = 8'($urandom_range(1, 9));
      if (hdr <= 8'd128) rand_data(4 * int'(hdr), dq);
      else dq = {};
      do_load(hdr, dq, int'($urandom_range(0, 2)), 8'd0, bit'($urandom_range(0, 1)));
    end

`ifdef LOADER_CHECKSUM_EN
    dq = {8'h12, 8'h34, 8'h56, 8'h78};
    do_load(8'h01, dq, 0, 8'd0, 1'b0);
    do_load(8'h01, dq, 0, 8'd1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that writes the instruction memory read by the processor control unit. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It appends a zero halt word and holds the control unit suspended and in reset until the load completes. It sits between the host/debug byte source and the instruction-memory write port.

## Interface
- `ADDR_WIDTH`, 7: instruction-memory address width.
- `DEPTH`, 128: number of instruction words; must equal 2^ADDR_WIDTH.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `byte_in`  in  8: stream data byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: loader accepts a byte; transfer occurs when `byte_valid && byte_ready`.
- `imem_addr`  out  ADDR_WIDTH: instruction-memory write address.
- `imem_data`  out  32: instruction-memory write data.
- `imem_we`  out  1: one-cycle write strobe.
- `cpu_hold`  out  1: drives the control unit's `controlSuspend`.
- `cpu_rst_n`  out  1: active-low reset to the control unit. Low while loading.
- `busy`  out  1: a load is in progress.
- `done`  out  1: last load completed successfully. Sticky until the next `start` or `rst`.
- `error`  out  1: last load was rejected. Sticky until the next `start` or `rst`.

## Operation
- States: IDLE, HEADER, BYTE, WRITE, TERM, CHECK, DONE, ERROR.
- IDLE: `start` moves to HEADER. The same transition applies from DONE and ERROR.
  - Clears `done` and `error`.
  - Sets `busy=1`, `cpu_hold=1`, `cpu_rst_n=0`.
  - Zeroes the word counter, byte counter and `imem_addr`.
- HEADER: `byte_ready=1`. The first accepted byte is the word count N.
  - 0 means 128 words.
  - 1–128 are legal.
  - 129–255 go to ERROR.
- BYTE: `byte_ready=1`. Accepted bytes shift into a 32-bit assembly register, MSB first. Byte counter runs 0..3.
  - The 4th byte moves to WRITE.
- WRITE: `byte_ready=0`. Drives `imem_we=1`, `imem_data` = assembled word, `imem_addr` = word index. Then increments the word index.
  - If more words remain: next state is BYTE.
  - Else if N<128: next state is TERM.
  - Else: next state is CHECK when `LOADER_CHECKSUM_EN` is defined, otherwise DONE.
- TERM: one `imem_we` pulse with data 0x00000000 at address N. This is the halt word that freezes the PC. Next state is CHECK or DONE.
- CHECK: present only with `LOADER_CHECKSUM_EN`.
- DONE: `done=1`, `busy=0`, `cpu_rst_n=1`, `cpu_hold=0`.
- ERROR: `error=1`, `busy=0`, `byte_ready=0`, `cpu_hold=1`, `cpu_rst_n=0`. Discards the remaining stream.
- Word index width is ADDR_WIDTH+1 so that 128 is representable. `imem_addr` takes the low ADDR_WIDTH bits and never wraps past DEPTH-1.
- `start` while `busy`: ignored.
- `byte_valid` while not ready: ignored, byte not consumed.
- `rst` mid-load: immediately aborts to IDLE. Partial writes stay in memory. The control unit stays held.

## Timing
- Reset values: state IDLE, `byte_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_data=0`, `cpu_hold=1`, `cpu_rst_n=0`, `busy=0`, `done=0`, `error=0`.
- All outputs are registered.
- `start` sampled at edge t: `byte_ready=1` from t+1.
- 4th byte of a word accepted at edge t: `imem_we=1` during cycle t+1 (after edge t), with addr/data stable. `byte_ready=1` again from t+2.
- Peak throughput: 4 bytes per 5 cycles.
- Last write (or TERM) at cycle t: `done` and `cpu_rst_n` rise at t+1. `cpu_hold` falls on the same edge, so the control unit leaves reset with `controlSuspend=0` and fetches address 0.
- Illegal header accepted at edge t: `error=1` from t+1.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined: after the final data word (and TERM), CHECK raises `byte_ready`. It accepts one checksum byte, which must equal the XOR of all data bytes (header excluded).
  - Match: DONE.
  - Mismatch: ERROR.
  - The running XOR clears on `start`.
- Undefined: the CHECK state and XOR register are absent. Flow goes straight to DONE. No trailing byte is consumed.

## Test plan
- Apply `rst`, then release → all outputs at reset values; `byte_ready=0` with `byte_valid=1` asserted.
- `start`; header 0x02; bytes F8 40 00 20 8B 02 00 41 → three writes: 0→0xF8400020, 1→0x8B020041, 2→0x00000000. Then `done=1`, `cpu_rst_n=1`, `cpu_hold=0`.
- `start`; header 0x00; 512 bytes → 128 writes, addresses 0..127, no TERM write, `done=1`. Word 127 contains the last 4 bytes.
- `start`; header 0x81 → `error=1` next cycle, no `imem_we`, `cpu_hold=1`, `cpu_rst_n=0`. A following `start` clears `error`.
- Header 0x01; bytes sent with random `byte_valid` gaps. `rst` asserted after 2 data bytes of a second load → first load writes the correct word. Reset returns to IDLE asynchronously with no further `imem_we`.
- With `LOADER_CHECKSUM_EN`: header 0x01; bytes 12 34 56 78; checksum 0x08 → `done=1`. Same load with checksum 0x09 → `error=1`.
